// File: rtl/regfile_uart_dump.sv
`default_nettype none
// ============================================================================
// Module   : regfile_uart_dump
// Function : Walks x0..x31 through the register file's auxiliary read port and
//            sends each value as an ASCII hex line ("II:VVVVVVVV\r\n") on UART 8N1.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_uart_dump #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [4:0]  reg_select,
  input  logic [31:0] reg_data,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam logic [1:0]  S_IDLE      = 2'd0;
  localparam logic [1:0]  S_LATCH     = 2'd1;
  localparam logic [1:0]  S_SEND      = 2'd2;
  localparam logic [15:0] C_BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [3:0]  C_BIT_STOP  = 4'd9;
  localparam logic [3:0]  C_CHAR_LAST = 4'd12;
  localparam logic [4:0]  C_IDX_LAST  = 5'd31;

  logic [1:0]  r_state;
  logic [1:0]  w_next;
  logic [15:0] r_clk_cnt;
  logic [3:0]  r_bit;
  logic [3:0]  r_char;
  logic [4:0]  r_idx;
  logic [31:0] r_snap;
  logic        r_done;
  logic        w_bit_end;
  logic        w_line_end;
  logic [3:0]  w_nib;
  logic [7:0]  w_byte;
  logic [2:0]  w_data_bit;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  assign w_bit_end  = (r_clk_cnt == C_BIT_LAST);
  assign w_line_end = w_bit_end && (r_bit == C_BIT_STOP) && (r_char == C_CHAR_LAST);
  assign w_data_bit = 3'(r_bit - 4'd1);

  // Character 3 carries snapshot[31:28], character 10 carries snapshot[3:0].
  always_comb begin
    w_nib  = 4'(r_snap >> {(4'd10 - r_char), 2'b00});
    w_byte = hex_ascii(w_nib);
    case (r_char)
      4'd0:    w_byte = hex_ascii({3'b000, r_idx[4]});
      4'd1:    w_byte = hex_ascii(r_idx[3:0]);
      4'd2:    w_byte = 8'h3A;
      4'd11:   w_byte = 8'h0D;
      4'd12:   w_byte = 8'h0A;
      default: w_byte = hex_ascii(w_nib);
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_LATCH;
      S_LATCH: w_next = S_SEND;
      S_SEND:  if (w_line_end) w_next = (r_idx == C_IDX_LAST) ? S_IDLE : S_LATCH;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    tx   = 1'b1;
    busy = 1'b0;
    case (r_state)
      S_LATCH: busy = 1'b1;
      S_SEND: begin
        busy = 1'b1;
        if (r_bit == 4'd0)            tx = 1'b0;
        else if (r_bit == C_BIT_STOP) tx = 1'b1;
        else                          tx = w_byte[w_data_bit];
      end
      default: ;
    endcase
  end

  assign done       = r_done;
  assign reg_select = r_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_clk_cnt <= 16'd0;
      r_bit     <= 4'd0;
      r_char    <= 4'd0;
      r_idx     <= 5'd0;
      r_snap    <= 32'd0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (start) r_idx <= 5'd0;
        S_LATCH: begin
          r_snap    <= reg_data;
          r_char    <= 4'd0;
          r_bit     <= 4'd0;
          r_clk_cnt <= 16'd0;
        end
        S_SEND: begin
          if (w_bit_end) begin
            r_clk_cnt <= 16'd0;
            if (r_bit == C_BIT_STOP) begin
              r_bit <= 4'd0;
              if (r_char == C_CHAR_LAST) begin
                r_char <= 4'd0;
                if (r_idx == C_IDX_LAST) r_done <= 1'b1;
                else                     r_idx  <= r_idx + 5'd1;
              end else begin
                r_char <= r_char + 4'd1;
              end
            end else begin
              r_bit <= r_bit + 4'd1;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_uart_dump.sv
`default_nettype none
// Bench for regfile_uart_dump: register-file model, UART frame decoder and a
// queue of expected line bytes filled whenever a dump is requested.
module tb_regfile_uart_dump;

  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  reg_select;
  logic [31:0] reg_data;
  logic        tx;
  logic        busy;
  logic        done;

  logic [31:0]  regs [32];
  byte unsigned exp_q [$];
  int checks = 0;
  int failures = 0;
  int run_len = 0;
  int last_run = 0;
  int done_total = 0;

  regfile_uart_dump #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .start(start), .reg_select(reg_select),
    .reg_data(reg_data), .tx(tx), .busy(busy), .done(done)
  );

  assign reg_data = regs[reg_select];
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (busy === 1'b1) run_len++;
    else if (run_len != 0) begin
      last_run = run_len;
      run_len  = 0;
    end
    if (done === 1'b1) done_total++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic byte unsigned hexc(input int n);
    return (n < 10) ? 8'(48 + n) : 8'(55 + n);
  endfunction

  task automatic push_line(input int idx);
    exp_q.push_back(hexc(idx / 16));
    exp_q.push_back(hexc(idx % 16));
    exp_q.push_back(8'h3A);
    for (int k = 7; k >= 0; k--) exp_q.push_back(hexc(int'((regs[idx] >> (4 * k)) & 32'hF)));
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  // Decode one frame sampled on falling edges; every bit must hold CPB samples.
  task automatic recv_frame(input bit poke, output logic [7:0] data, output int gap, output bit ok);
    logic [9:0] bits;
    bit got_start;
    got_start = 1'b0;
    gap = 0;
    ok = 1'b1;
    data = 8'h00;
    bits = 10'h0;
    while (!got_start && gap <= 2000) begin
      @(negedge clk);
      if (tx === 1'b0) got_start = 1'b1;
      else gap++;
    end
    if (!got_start) begin
      ok = 1'b0;
      return;
    end
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < CPB; c++) begin
        if (!(b == 0 && c == 0)) @(negedge clk);
        if (poke && b == 0 && c == 0) start = 1'b1;
        if (poke && b == 0 && c == 1) start = 1'b0;
        if (c == 0) bits[b] = tx;
        else if (tx !== bits[b]) ok = 1'b0;
      end
    end
    if (bits[0] !== 1'b0 || bits[9] !== 1'b1) ok = 1'b0;
    data = bits[8:1];
  endtask

  task automatic recv_check(input int line, input int bidx, input int gap_exp, input bit poke);
    logic [7:0] d;
    logic [7:0] e;
    int gap;
    bit ok;
    recv_frame(poke, d, gap, ok);
    check($sformatf("L%0d B%0d framing", line, bidx), 32'(ok), 32'd1);
    check($sformatf("L%0d B%0d gap", line, bidx), gap, gap_exp);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    check($sformatf("L%0d B%0d data", line, bidx), 32'(d), 32'(e));
  endtask

  initial begin
    int ok_cnt;
    int done_before;
    for (int i = 0; i < 32; i++) regs[i] = 32'h0;
    regs[2]  = 32'h00000FFC;
    regs[5]  = 32'h11111111;
    regs[31] = 32'hDEADBEEF;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset tx", 32'(tx), 32'd1);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset reg_select", 32'(reg_select), 32'd0);
    rst = 1'b0;
    ok_cnt = 0;
    repeat (1000) begin
      @(negedge clk);
      if (tx === 1'b1 && busy === 1'b0) ok_cnt++;
    end
    check("idle tx high 1000 cycles", ok_cnt, 1000);

    // Dump 1: content, timing, snapshot stability, ignored start while busy.
    done_before = done_total;
    start = 1'b1;
    for (int i = 0; i < 32; i++) push_line(i);
    @(negedge clk);
    start = 1'b0;
    check("dump1 latch busy", 32'(busy), 32'd1);
    for (int l = 0; l < 32; l++) begin
      for (int b = 0; b < 13; b++) begin
        if (l == 5 && b == 4) regs[5] = 32'h22222222;
        if (l == 31 && b == 12) start = 1'b1;
        recv_check(l, b, (b == 0 && l != 0) ? 1 : 0, (l == 0 && b == 12));
        if (b == 0) check($sformatf("L%0d reg_select", l), 32'(reg_select), l);
      end
    end
    @(negedge clk);
    check("done pulse", 32'(done), 32'd1);
    check("busy low in done cycle", 32'(busy), 32'd0);
    for (int i = 0; i < 32; i++) push_line(i);
    @(negedge clk);
    start = 1'b0;
    check("restart busy after done", 32'(busy), 32'd1);
    check("done one cycle", 32'(done), 32'd0);
    check("restart reg_select", 32'(reg_select), 32'd0);
    check("dump1 busy length", last_run, 32 * (1 + 130 * CPB));
    check("dump1 done count", done_total - done_before, 1);

    // Dump 2: runs until a data bit of register 7, then reset.
    for (int l = 0; l < 8; l++) begin
      for (int b = 0; b < 13; b++) begin
        if (l == 7 && b == 3) break;
        recv_check(100 + l, b, (b == 0 && l != 0) ? 1 : 0, 1'b0);
      end
    end
    repeat (5) @(negedge clk);
    check("reg7 data bit0 low", 32'(tx), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("midreset tx", 32'(tx), 32'd1);
    check("midreset busy", 32'(busy), 32'd0);
    check("midreset done", 32'(done), 32'd0);
    check("midreset reg_select", 32'(reg_select), 32'd0);
    rst = 1'b0;
    exp_q.delete();

    // Dump 3: must begin again from x0.
    repeat (5) @(negedge clk);
    check("post-reset idle tx", 32'(tx), 32'd1);
    start = 1'b1;
    push_line(0);
    @(negedge clk);
    start = 1'b0;
    check("dump3 busy", 32'(busy), 32'd1);
    for (int b = 0; b < 13; b++) recv_check(200, b, 0, 1'b0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
